// File: rtl/clock_pkg.sv
// Shared types and default timing for the clock-setting controller.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_S = 2'd1,
        SET_M = 2'd2,
        SET_H = 2'd3
    } mode_t;

    localparam int DEF_CLK_HZ       = 100000;
    localparam int DEF_DEBOUNCE_CYC = 1000;
    localparam int DEF_REPEAT_DELAY = 50000;
    localparam int DEF_REPEAT_RATE  = 10000;
    localparam int DEF_BLINK_HALF   = 25000;

    // Mode sequence stepped by each mode_set press.
    function automatic mode_t nextMode(input mode_t m);
        case (m)
            RUN:     return SET_S;
            SET_S:   return SET_M;
            SET_M:   return SET_H;
            default: return RUN;
        endcase
    endfunction

    // One-hot field selection {h, m, s} for the current mode; zero in RUN.
    function automatic logic [2:0] fieldSelect(input mode_t m);
        case (m)
            SET_S:   return 3'b001;
            SET_M:   return 3'b010;
            SET_H:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus counting debouncer for one active-low key.
// A key that is already held when reset ends is ignored until it has been
// seen released once, so holding a key through reset never fires an event.
module key_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk100khz,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_settle;
    logic          r_armed;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_count;

    // Bring the raw key into the clock domain; idle state is released.
    always_ff @(posedge clk100khz) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Arm only once the synchronizer holds real samples showing the key released.
    always_ff @(posedge clk100khz) begin
        if (rst) begin
            r_settle <= 2'd0;
            r_armed  <= 1'b0;
        end else begin
            if (r_settle != 2'd2)
                r_settle <= r_settle + 2'd1;
            if (r_settle == 2'd2 && r_sync2)
                r_armed <= 1'b1;
        end
    end

    // Flip the accepted level after a full run of mismatching samples; flag the press edge.
    always_ff @(posedge clk100khz) begin
        if (rst) begin
            r_level <= 1'b1;
            r_press <= 1'b0;
            r_count <= '0;
        end else begin
            r_press <= 1'b0;
            if (!r_armed || r_sync2 == r_level) begin
                r_count <= '0;
            end else if (r_count == LAST) begin
                r_level <= r_sync2;
                r_press <= ~r_sync2;
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/clock_set_ctrl.sv
// Front-panel controller for setting a clock: mode stepping, inc/dec pulses
// with auto-repeat, the 1 Hz seconds tick and the field blink.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
    input  logic       clk100khz,
    input  logic       rst,
    input  logic       mode_set_n,
    input  logic       inc_n,
    input  logic       dec_n,
    output logic [1:0] mode,
    output logic       tick_s,
    output logic       inc_s,
    output logic       inc_m,
    output logic       inc_h,
    output logic       dec_s,
    output logic       dec_m,
    output logic       dec_h,
    output logic       blink
);

    localparam int PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam int BW      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [PW-1:0] TICK_LAST  = PW'(CLK_HZ - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic w_unusedModeLevel;
    logic w_modePress;
    logic w_incLvl;
    logic w_incPress;
    logic w_decLvl;
    logic w_decPress;
    logic w_bothDown;
    logic [2:0] w_field;
    logic [RW-1:0] w_repLast;

    mode_t         r_mode;
    logic [2:0]    r_inc;
    logic [2:0]    r_dec;
    logic          r_repActive;
    logic          r_repIsInc;
    logic          r_repFirst;
    logic [RW-1:0] r_repCnt;
    logic [PW-1:0] r_preCnt;
    logic          r_tick;
    logic [BW-1:0] r_blinkCnt;
    logic          r_blink;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_modeKey (
        .clk100khz(clk100khz), .rst(rst), .key_n(mode_set_n),
        .level(w_unusedModeLevel), .press(w_modePress)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_incKey (
        .clk100khz(clk100khz), .rst(rst), .key_n(inc_n),
        .level(w_incLvl), .press(w_incPress)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_decKey (
        .clk100khz(clk100khz), .rst(rst), .key_n(dec_n),
        .level(w_decLvl), .press(w_decPress)
    );

    assign w_bothDown = ~w_incLvl & ~w_decLvl;
    assign w_field    = fieldSelect(r_mode);
    assign w_repLast  = r_repFirst ? DELAY_LAST : RATE_LAST;

    // Mode FSM: each mode_set press advances RUN -> SET_S -> SET_M -> SET_H -> RUN.
    always_ff @(posedge clk100khz) begin
        if (rst)
            r_mode <= RUN;
        else if (w_modePress)
            r_mode <= nextMode(r_mode);
    end

    // Inc/dec pulses for the selected field; a new press is needed after any cancel.
    always_ff @(posedge clk100khz) begin
        if (rst) begin
            r_inc       <= 3'b000;
            r_dec       <= 3'b000;
            r_repActive <= 1'b0;
            r_repIsInc  <= 1'b0;
            r_repFirst  <= 1'b0;
            r_repCnt    <= '0;
        end else begin
            r_inc <= 3'b000;
            r_dec <= 3'b000;
            if (w_modePress || r_mode == RUN || w_bothDown) begin
                r_repActive <= 1'b0;
                r_repCnt    <= '0;
            end else if (w_incPress || w_decPress) begin
                if (w_incPress)
                    r_inc <= w_field;
                else
                    r_dec <= w_field;
                r_repActive <= 1'b1;
                r_repIsInc  <= w_incPress;
                r_repFirst  <= 1'b1;
                r_repCnt    <= '0;
            end else if (r_repActive) begin
                if (r_repIsInc ? w_incLvl : w_decLvl) begin
                    r_repActive <= 1'b0;
                    r_repCnt    <= '0;
                end else if (r_repCnt == w_repLast) begin
                    if (r_repIsInc)
                        r_inc <= w_field;
                    else
                        r_dec <= w_field;
                    r_repFirst <= 1'b0;
                    r_repCnt   <= '0;
                end else begin
                    r_repCnt <= r_repCnt + 1'b1;
                end
            end
        end
    end

    // Seconds prescaler runs only in RUN and restarts from zero on every return.
    always_ff @(posedge clk100khz) begin
        if (rst || r_mode != RUN || w_modePress) begin
            r_preCnt <= '0;
            r_tick   <= 1'b0;
        end else if (r_preCnt == TICK_LAST) begin
            r_preCnt <= '0;
            r_tick   <= 1'b1;
        end else begin
            r_preCnt <= r_preCnt + 1'b1;
            r_tick   <= 1'b0;
        end
    end

    // Blink the selected field in SET modes, restarting the phase at each mode change.
    always_ff @(posedge clk100khz) begin
        if (rst || r_mode == RUN || w_modePress) begin
            r_blinkCnt <= '0;
            r_blink    <= 1'b0;
        end else if (r_blinkCnt == BLINK_LAST) begin
            r_blinkCnt <= '0;
            r_blink    <= ~r_blink;
        end else begin
            r_blinkCnt <= r_blinkCnt + 1'b1;
        end
    end

    assign mode   = r_mode;
    assign tick_s = r_tick;
    assign inc_s  = r_inc[0];
    assign inc_m  = r_inc[1];
    assign inc_h  = r_inc[2];
    assign dec_s  = r_dec[0];
    assign dec_m  = r_dec[1];
    assign dec_h  = r_dec[2];
    assign blink  = r_blink;

endmodule
